// File: rtl/dw_systolic_engine.sv
// Depthwise-convolution row engine: NUM_ROWS parallel KSIZE x KSIZE dot
// products over a sliding column window, with tile FSM, valid/ready
// streams, double-buffered weights and optional horizontal stride 2.

// One output row: psum + sum_{i,j} w[i][j] * taps[i][j], wrapping.
module dw_row_mac #(
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int KSIZE          = 3
) (
  input  logic [0:KSIZE-1][0:KSIZE-1][DATA_WIDTH-1:0] taps,
  input  logic [0:KSIZE*KSIZE-1][DATA_WIDTH-1:0]      wgt,
  input  logic [OUT_DATA_WIDTH-1:0]                   psum,
  output logic [OUT_DATA_WIDTH-1:0]                   sum
);
  localparam int PW = 2*DATA_WIDTH;

  // Signed products accumulated onto the incoming partial sum.
  always_comb begin
    logic signed [PW-1:0] sa, sw, prod;
    sum  = psum;
    sa   = '0;
    sw   = '0;
    prod = '0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        sa   = PW'($signed(taps[i][j]));
        sw   = PW'($signed(wgt[i*KSIZE+j]));
        prod = sa * sw;
        sum  = sum + OUT_DATA_WIDTH'(prod);
      end
    end
  end
endmodule

module dw_systolic_engine #(
  parameter  int DATA_WIDTH     = 8,
  parameter  int OUT_DATA_WIDTH = 32,
  parameter  int KSIZE          = 3,
  parameter  int NUM_ROWS       = 3,
  localparam int NUM_IN         = NUM_ROWS + KSIZE - 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [15:0]                        tile_width,
  input  logic                               stride_2,
  input  logic                               wgt_load,
  input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]  wgt_data,
  input  logic                               act_valid,
  output logic                               act_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0]       act_data,
  input  logic [NUM_ROWS*OUT_DATA_WIDTH-1:0] result_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_ROWS*OUT_DATA_WIDTH-1:0] result,
  output logic                               busy,
  output logic                               done
);
  localparam int NW = KSIZE*KSIZE;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  // Parity of the KSIZE-1 offset between col_cnt and output position.
  localparam logic K1_ODD = ((KSIZE - 1) % 2) != 0;

  typedef struct packed {
    logic [15:0] width;
    logic        stride_2;
  } tile_cfg_t;

  logic [1:0]  state;
  logic [15:0] col_cnt;
  tile_cfg_t   cfg;

  logic [0:NW-1][DATA_WIDTH-1:0]                     w_shadow, w_active;
  logic [0:NUM_IN-1][DATA_WIDTH-1:0]                 act_col;
  logic [0:NUM_IN-1][0:KSIZE-2][DATA_WIDTH-1:0]      win;
  logic [0:NUM_IN-1][0:KSIZE-1][DATA_WIDTH-1:0]      win_ext;
  logic [0:NUM_ROWS-1][OUT_DATA_WIDTH-1:0]           psum_in, sums, res_q;

  logic accept, start_ok, last_col, pos_odd, emit;

  assign act_col = act_data;
  assign psum_in = result_in;
  assign result  = res_q;
  assign busy    = (state != S_IDLE);

  assign act_ready = !reset && busy && (!out_valid || out_ready);
  assign accept    = act_valid && act_ready;
  assign start_ok  = (state == S_IDLE) && start && (tile_width != '0);
  assign last_col  = (col_cnt == cfg.width - 16'd1);
  assign pos_odd   = col_cnt[0] ^ K1_ODD;
  // In RUN every accepted column has a valid position; stride 2 keeps even ones.
  assign emit      = accept && (state == S_RUN) && (!cfg.stride_2 || !pos_odd);

  // Full window per input row: stored history followed by the incoming column.
  for (genvar r = 0; r < NUM_IN; r++) begin : g_ext
    assign win_ext[r] = {win[r], act_col[r]};
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    dw_row_mac #(
      .DATA_WIDTH(DATA_WIDTH), .OUT_DATA_WIDTH(OUT_DATA_WIDTH), .KSIZE(KSIZE)
    ) u_mac (
      .taps (win_ext[r +: KSIZE]),
      .wgt  (w_active),
      .psum (psum_in[r]),
      .sum  (sums[r])
    );
  end

  // Tile FSM: column counting, FILL->RUN after KSIZE-1 columns, done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      col_cnt <= '0;
      cfg     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start_ok) begin
          state   <= S_FILL;
          col_cnt <= '0;
          cfg     <= '{width: tile_width, stride_2: stride_2};
        end
      end else if (accept) begin
        col_cnt <= col_cnt + 16'd1;
        if (last_col) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end else if (state == S_FILL && col_cnt == 16'(KSIZE-2)) begin
          state <= S_RUN;
        end
      end
    end
  end

  // Weight banks: loads land in shadow; start copies shadow (or bypassed data) to active.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_shadow <= '0;
      w_active <= '0;
    end else begin
      if (wgt_load) w_shadow <= wgt_data;
      if (start_ok) w_active <= wgt_load ? wgt_data : w_shadow;
    end
  end

  // Column window: shift oldest out, incoming column becomes newest stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      win <= '0;
    end else if (accept) begin
      for (int r = 0; r < NUM_IN; r++) begin
        for (int j = 0; j < KSIZE-2; j++) win[r][j] <= win[r][j+1];
        win[r][KSIZE-2] <= act_col[r];
      end
    end
  end

  // Output register: load on emit, hold under backpressure, clear on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      res_q     <= sums;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/dw_systolic_engine.md
# dw_systolic_engine

Parametrised depthwise-convolution row engine: next generation of the fixed 3-row depthwise systolic array, with KSIZE×KSIZE kernel and NUM_ROWS parallel output rows set by parameters. It adds a tile-control FSM, a valid/ready stream on activations and results, double-buffered weights and a horizontal stride-2 mode. It sits between the activation line buffer, which feeds NUM_IN rows one column per beat, and the partial-sum accumulator / requantiser, which consumes NUM_ROWS results per beat.

## Interface
- DATA_WIDTH, 8, signed activation/weight width
- OUT_DATA_WIDTH, 32, signed result / partial-sum width (≥ 2*DATA_WIDTH + clog2(KSIZE*KSIZE))
- KSIZE, 3, kernel height and width (≥ 2)
- NUM_ROWS, 3, output rows computed in parallel
- NUM_IN, NUM_ROWS+KSIZE-1, activation rows per column (derived; not overridden)
- clk  in  1  clock. Single clock domain.
- reset  in  1  synchronous, active-high reset
- start  in  1  begin tile; honoured only in IDLE
- tile_width  in  16  columns in tile; sampled with accepted start
- stride_2  in  1  1 = horizontal stride 2; sampled with accepted start
- wgt_load  in  1  load wgt_data into shadow weight bank
- wgt_data  in  KSIZE*KSIZE*DATA_WIDTH  w[i][j] at slice i*KSIZE+j; slice 0 at MSBs
- act_valid  in  1  activation column valid
- act_ready  out  1  engine accepts column
- act_data  in  NUM_IN*DATA_WIDTH  one column; row 0 at MSBs
- result_in  in  NUM_ROWS*OUT_DATA_WIDTH  per-row partial sum, row 0 at MSBs; sampled with the column that produces an output
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  NUM_ROWS*OUT_DATA_WIDTH  row 0 at MSBs
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle tile-complete pulse

## Operation
- FSM states: IDLE, FILL, RUN.
- IDLE → FILL on start with tile_width ≠ 0. Start with tile_width = 0 is ignored. Start outside IDLE is ignored.
- On accepted start: col_cnt ← 0; active weights ← shadow. If wgt_load is in the same cycle, the incoming wgt_data goes to both banks (bypass).
- wgt_load is legal in any state. It only writes shadow, so the active bank is never disturbed mid-tile.
- Window: the engine keeps the last KSIZE-1 accepted columns per input row. Column j = 0 is the oldest; the incoming column is j = KSIZE-1.
- FILL → RUN when column KSIZE-2 is accepted (col_cnt reaches KSIZE-1).
- Position p = col_cnt - (KSIZE-1) for the column being accepted in RUN.
- An output is produced when p is valid and (stride_2 = 0 or p even):
  - result[r] = result_in[r] + Σ_{i,j} w[i][j]·a[r+i][j], for r in 0..NUM_ROWS-1.
- Arithmetic: signed products, sign-extended to OUT_DATA_WIDTH, sum wraps modulo 2^OUT_DATA_WIDTH.
- The column with col_cnt = tile_width-1 is the last. After accepting it: → IDLE and done pulses.
- If tile_width < KSIZE, no output is ever produced, but done still pulses.
- Window contents are not cleared between tiles. The FILL phase masks them.

## Timing
- act_ready = (state ∈ {FILL, RUN}) && (!out_valid || out_ready). It is 0 in IDLE and 0 during reset.
- Column accepted at edge t: window and col_cnt update at t. If the column produces an output, result and out_valid = 1 are registered at t, so latency is 1 cycle.
- The output register holds result stable while out_valid && !out_ready.
- out_valid clears on the handshake edge unless a new output loads on the same edge; back-to-back outputs need no bubble.
- done = 1 for exactly the cycle after the last column is accepted. It coincides with the first cycle of that column's out_valid, if it produced one. busy falls in the same cycle.
- A new start is accepted in the cycle done is high. It is also accepted while a final result is still pending; act_ready then waits for out_ready.
- Reset (any state, mid-tile) applies at the next edge:
  - state IDLE; col_cnt, window and both weight banks zeroed;
  - act_ready, out_valid, busy, done = 0; result = 0;
  - any pending output is discarded.

## Test plan
- Ones: KSIZE = 3, NUM_ROWS = 3, all weights 1, all activations 1, result_in = {0, 5, -3}, tile_width = 5, stride 1 → exactly 3 outputs, each {9, 14, 6}, first out_valid one cycle after the 3rd accepted column; done after the 5th.
- Stride/sign: tile_width = 7, stride_2 = 1, weights = -1, activations = 2 → 3 outputs (p = 0, 2, 4), each row = -18 + result_in; p = 1, 3 produce no out_valid.
- Backpressure: hold out_ready = 0 for 4 cycles with act_valid = 1 → act_ready = 0, result stable; release → no output lost or duplicated, order preserved.
- Weight double-buffer: wgt_load of weights 2 mid-tile → current tile still uses 1s. Next start uses 2s → outputs {18+result_in}. wgt_load and start in the same cycle → new weights used.
- Boundaries: tile_width = 2 → no outputs, done after 2nd column. tile_width = 0 start → ignored, busy stays 0. Start while busy → ignored.
- Reset mid-tile: reset while out_valid = 1 and out_ready = 0 → next cycle all outputs 0 and state IDLE. A fresh tile then matches the ones case exactly.
